ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_ctrl.sv | 122 ++++++++++++
 tb/tb_ram_bist_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: two-pass RAM self-test initiator (seeded pattern, then its inverse), reports pass/fail and first failing address
// Ports: i_Clk/i_Rst_L (sync, active low); i_Start/i_Seed start a run; o_Busy/o_Done/o_Pass/o_Fail_Pass/o_Fail_Addr status;
// o_Addr/o_Wr_DV/o_Wr_Data/o_Rd_En drive the RAM; i_Rd_DV/i_Rd_Data return read data one cycle after o_Rd_En.
// Optional macro RAM_BIST_STOP_ON_FAIL_EN: first mismatch or drain timeout ends the run immediately.
module ram_bist_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Start,
    input  logic [WIDTH-1:0]         i_Seed,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Pass,
    output logic                     o_Fail_Pass,
    output logic [$clog2(DEPTH)-1:0] o_Fail_Addr,
    output logic [$clog2(DEPTH)-1:0] o_Addr,
    output logic                     o_Wr_DV,
    output logic [WIDTH-1:0]         o_Wr_Data,
    output logic                     o_Rd_En,
    input  logic                     i_Rd_DV,
    input  logic [WIDTH-1:0]         i_Rd_Data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WR_A, RD_A, DRAIN_A, WR_B, RD_B, DRAIN_B, DONE} state_t;

    state_t state, state_nxt;
    logic [WIDTH-1:0] seed, seed_nxt, wr_data_nxt;
    logic [AW-1:0] cmp_cnt, cmp_nxt, addr_nxt, fail_addr_nxt;
    logic [2:0] tmo_cnt, tmo_nxt;
    logic cmp_done, cmp_done_nxt, in_cmp_nxt;
    logic start_ok, is_wr, is_rd, is_drain, pass_b;
    logic rd_ok, last_rsp, all_rsp, mismatch, timeout, fail_evt;
    logic pass_nxt, fail_pass_nxt;

    function automatic logic [WIDTH-1:0] pat(input logic [WIDTH-1:0] s, input logic [AW-1:0] a, input logic b);
        pat = (s + WIDTH'(a)) ^ {WIDTH{b}};
    endfunction

    // Compare side runs off its own response counter so RAM latency never skews the expected value.
    always_comb begin
        start_ok = i_Start && (state == IDLE || state == DONE);
        is_wr    = state inside {WR_A, WR_B};
        is_rd    = state inside {RD_A, RD_B};
        is_drain = state inside {DRAIN_A, DRAIN_B};
        pass_b   = state inside {WR_B, RD_B, DRAIN_B};
        rd_ok    = i_Rd_DV && (is_rd || is_drain) && !cmp_done;
        last_rsp = rd_ok && cmp_cnt == LAST;
        all_rsp  = cmp_done || last_rsp;
        mismatch = rd_ok && i_Rd_Data != pat(seed, cmp_cnt, pass_b);
        timeout  = is_drain && !all_rsp && tmo_cnt == 3'd7;
        fail_evt = mismatch || timeout;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start_ok ? WR_A : state;
            WR_A:       state_nxt = o_Addr == LAST ? RD_A : WR_A;
            RD_A:       state_nxt = o_Addr == LAST ? DRAIN_A : RD_A;
            DRAIN_A:    state_nxt = (all_rsp || timeout) ? WR_B : DRAIN_A;
            WR_B:       state_nxt = o_Addr == LAST ? RD_B : WR_B;
            RD_B:       state_nxt = o_Addr == LAST ? DRAIN_B : RD_B;
            DRAIN_B:    state_nxt = (all_rsp || timeout) ? DONE : DRAIN_B;
            default:    state_nxt = IDLE;
        endcase
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        if (fail_evt) state_nxt = DONE;
`endif
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        seed_nxt      = start_ok ? i_Seed : seed;
        addr_nxt      = ((is_wr || is_rd) && o_Addr != LAST && state_nxt inside {WR_A, RD_A, WR_B, RD_B}) ? o_Addr + 1'b1 : '0;
        in_cmp_nxt    = state_nxt inside {RD_A, DRAIN_A, RD_B, DRAIN_B};
        cmp_nxt       = !in_cmp_nxt ? '0 : rd_ok ? (last_rsp ? '0 : cmp_cnt + 1'b1) : cmp_cnt;
        cmp_done_nxt  = in_cmp_nxt && all_rsp;
        tmo_nxt       = (is_drain && state_nxt == state) ? tmo_cnt + 3'd1 : '0;
        pass_nxt      = start_ok || (o_Pass && !fail_evt);
        fail_pass_nxt = start_ok ? 1'b0 : (fail_evt && o_Pass) ? pass_b : o_Fail_Pass;
        fail_addr_nxt = start_ok ? '0 : (fail_evt && o_Pass) ? cmp_cnt : o_Fail_Addr;
        wr_data_nxt   = (state_nxt inside {WR_A, WR_B}) ? pat(seed_nxt, addr_nxt, state_nxt == WR_B) : '0;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            seed        <= '0;
            cmp_cnt     <= '0;
            cmp_done    <= 1'b0;
            tmo_cnt     <= '0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Pass      <= 1'b1;
            o_Fail_Pass <= 1'b0;
            o_Fail_Addr <= '0;
            o_Addr      <= '0;
            o_Wr_DV     <= 1'b0;
            o_Wr_Data   <= '0;
            o_Rd_En     <= 1'b0;
        end else begin
            state       <= state_nxt;
            seed        <= seed_nxt;
            cmp_cnt     <= cmp_nxt;
            cmp_done    <= cmp_done_nxt;
            tmo_cnt     <= tmo_nxt;
            o_Busy      <= !(state_nxt inside {IDLE, DONE});
            o_Done      <= state_nxt == DONE;
            o_Pass      <= pass_nxt;
            o_Fail_Pass <= fail_pass_nxt;
            o_Fail_Addr <= fail_addr_nxt;
            o_Addr      <= addr_nxt;
            o_Wr_DV     <= state_nxt inside {WR_A, WR_B};
            o_Wr_Data   <= wr_data_nxt;
            o_Rd_En     <= state_nxt inside {RD_A, RD_B};
        end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed self-checking bench for ram_bist_ctrl with a 1-cycle RAM model
module tb_ram_bist_ctrl;
    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Start = 1'b0;
    logic [7:0] i_Seed = 8'h00;
    logic       i_Rd_DV = 1'b0;
    logic [7:0] i_Rd_Data = 8'h00;
    logic       o_Busy, o_Done, o_Pass, o_Fail_Pass, o_Wr_DV, o_Rd_En;
    logic [1:0] o_Fail_Addr, o_Addr;
    logic [7:0] o_Wr_Data;

    logic [7:0]  mem [4];
    logic        fault_en = 1'b0;
    logic        no_rsp = 1'b0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cyc, wr_n, hits;
    logic [63:0] wlog;
    logic [15:0] alog;

    always #5 i_Clk = ~i_Clk;

    ram_bist_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start), .i_Seed(i_Seed),
        .o_Busy(o_Busy), .o_Done(o_Done), .o_Pass(o_Pass), .o_Fail_Pass(o_Fail_Pass),
        .o_Fail_Addr(o_Fail_Addr), .o_Addr(o_Addr), .o_Wr_DV(o_Wr_DV), .o_Wr_Data(o_Wr_Data),
        .o_Rd_En(o_Rd_En), .i_Rd_DV(i_Rd_DV), .i_Rd_Data(i_Rd_Data)
    );

    // RAM model; the fault flips bit0 at addr 2 only once pass B writes have begun (more than 4 writes in this run).
    always @(posedge i_Clk) begin
        if (o_Wr_DV) mem[o_Addr] <= o_Wr_Data;
        i_Rd_DV   <= o_Rd_En && !no_rsp;
        i_Rd_Data <= mem[o_Addr] ^ {7'd0, fault_en && wr_cnt > 4 && o_Addr == 2'd2};
        wr_cnt    <= !o_Busy ? 0 : wr_cnt + int'(o_Wr_DV);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_bist(input logic [7:0] seed, input bit hold);
        i_Seed  = seed;
        i_Start = 1'b1;
        @(negedge i_Clk);
        if (!hold) i_Start = 1'b0;
        busy_cyc = 0;
        wr_n = 0;
        wlog = '0;
        alog = '0;
        for (int c = 0; c < 100 && !o_Done; c++) begin
            busy_cyc += int'(o_Busy);
            if (o_Wr_DV) begin
                wr_n++;
                wlog = {wlog[55:0], o_Wr_Data};
                alog = {alog[13:0], o_Addr};
            end
            @(negedge i_Clk);
        end
        i_Start = 1'b0;
        check("done", 64'(o_Done), 64'd1);
    endtask

    task automatic quiet_after_done();
        hits = 0;
        repeat (3) begin
            @(negedge i_Clk);
            hits += int'(o_Wr_DV || o_Rd_En);
        end
        check("no_strobes_after_done", 64'(hits), 64'd0);
        check("done_held", 64'(o_Done), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge i_Clk);
        check("rst_busy", 64'(o_Busy), 64'd0);
        check("rst_done", 64'(o_Done), 64'd0);
        check("rst_pass", 64'(o_Pass), 64'd1);
        check("rst_wr", 64'(o_Wr_DV), 64'd0);
        check("rst_rd", 64'(o_Rd_En), 64'd0);
        check("rst_fail_addr", 64'(o_Fail_Addr), 64'd0);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);

        run_bist(8'h01, 1'b0);
        check("clean_busy", 64'(busy_cyc), 64'd18);
        check("clean_pass", 64'(o_Pass), 64'd1);
        check("clean_wr_n", 64'(wr_n), 64'd8);
        check("clean_wdata", wlog, 64'h01020304_FEFDFCFB);
        check("clean_waddr", 64'(alog), 64'h1B1B);
        quiet_after_done();

        fault_en = 1'b1;
        run_bist(8'h01, 1'b0);
        check("fault_pass", 64'(o_Pass), 64'd0);
        check("fault_fail_pass", 64'(o_Fail_Pass), 64'd1);
        check("fault_fail_addr", 64'(o_Fail_Addr), 64'd2);
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        check("fault_busy", 64'(busy_cyc), 64'd17);
`else
        check("fault_busy", 64'(busy_cyc), 64'd18);
`endif
        quiet_after_done();
        fault_en = 1'b0;

        run_bist(8'hFE, 1'b1);
        check("wrap_busy", 64'(busy_cyc), 64'd18);
        check("wrap_pass", 64'(o_Pass), 64'd1);
        check("wrap_wr_n", 64'(wr_n), 64'd8);
        check("wrap_wdata", wlog, 64'hFEFF0001_0100FFFE);

        no_rsp = 1'b1;
        run_bist(8'h01, 1'b0);
        check("tmo_pass", 64'(o_Pass), 64'd0);
        check("tmo_fail_pass", 64'(o_Fail_Pass), 64'd0);
        check("tmo_fail_addr", 64'(o_Fail_Addr), 64'd0);
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        check("tmo_busy", 64'(busy_cyc), 64'd16);
`else
        check("tmo_busy", 64'(busy_cyc), 64'd32);
`endif
        quiet_after_done();
        no_rsp = 1'b0;

        i_Seed  = 8'h01;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (4) @(negedge i_Clk);
        check("pre_rst_rd", 64'(o_Rd_En), 64'd1);
        i_Rst_L = 1'b0;
        @(negedge i_Clk);
        check("midrst_rd", 64'(o_Rd_En), 64'd0);
        check("midrst_wr", 64'(o_Wr_DV), 64'd0);
        check("midrst_busy", 64'(o_Busy), 64'd0);
        check("midrst_done", 64'(o_Done), 64'd0);
        check("midrst_pass", 64'(o_Pass), 64'd1);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        run_bist(8'h01, 1'b0);
        check("after_rst_busy", 64'(busy_cyc), 64'd18);
        check("after_rst_pass", 64'(o_Pass), 64'd1);
        check("after_rst_wdata", wlog, 64'h01020304_FEFDFCFB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
